cachepool_id_remapper: RTL and testbench
========================================

# cachepool_id_remapper

Parametrised transaction-ID remapper for one CachePool L2 channel. It compresses a wide upstream ID space (the cluster's crossbar-extended IDs) onto a narrow downstream ID space, so no per-channel protocol converter is needed. A remap table tracks outstanding transactions per unique ID and throttles issue when the table or a per-ID counter is full. One instance sits on each of the `NumL2Channel` ports between the cluster master port and L2. Request and response paths are handled as generic valid/ready channels carrying an ID and an opaque payload.

## Interface
- `InIdWidth`, 6, upstream ID width
- `OutIdWidth`, 2, downstream ID width; table has `2**OutIdWidth` entries
- `MaxTxnsPerId`, 4, max outstanding transactions per table entry (>=1)
- `ReqWidth`, 64, request payload width (passed through untouched)
- `RspWidth`, 64, response payload width (passed through untouched)
- `clk_i`  in  1  clock
- `rst_i`  in  1  reset, asynchronous, active-high
- `req_valid_i` / `req_ready_o`  in/out  1  upstream request handshake
- `req_id_i`  in  InIdWidth  upstream request ID
- `req_data_i`  in  ReqWidth  request payload
- `req_valid_o` / `req_ready_i`  out/in  1  downstream request handshake
- `req_id_o`  out  OutIdWidth  remapped ID (table index)
- `req_data_o`  out  ReqWidth  = `req_data_i`
- `rsp_valid_i` / `rsp_ready_o`  in/out  1  downstream response handshake
- `rsp_id_i`  in  OutIdWidth  downstream response ID
- `rsp_last_i`  in  1  final beat of the transaction
- `rsp_data_i`  in  RspWidth  response payload
- `rsp_valid_o` / `rsp_ready_i`  out/in  1  upstream response handshake
- `rsp_id_o`  out  InIdWidth  restored upstream ID
- `rsp_last_o`  out  1  = `rsp_last_i`
- `rsp_data_o`  out  RspWidth  = `rsp_data_i`
- `busy_o`  out  1  any table entry valid
- `err_o`  out  1  sticky: response arrived for an invalid entry

## Operation
- Table entry e: `vld`, `in_id[InIdWidth]`, `cnt[$clog2(MaxTxnsPerId+1)]`.
- Request lookup:
  - If a valid entry has `in_id == req_id_i`, that entry is the hit. At most one entry can match.
  - On a hit with `cnt < MaxTxnsPerId`, issue is allowed with `req_id_o = e`.
  - On a hit with `cnt == MaxTxnsPerId`, the request stalls.
  - On a miss, the lowest-index entry with `vld==0` is allocated. If no entry is free, the request stalls.
- `req_valid_o = req_valid_i & can_issue`; `req_ready_o = req_ready_i & can_issue`.
- On request handshake: allocate the entry if needed (`vld<=1`, `in_id<=req_id_i`) and increment `cnt`.
- Response path:
  - `rsp_id_o = in_id[rsp_id_i]`.
  - `rsp_valid_o = rsp_valid_i`; `rsp_ready_o = rsp_ready_i`.
- On a response handshake with `rsp_last_i`, `cnt[rsp_id_i]` decrements. When it reaches 0, `vld` clears.
- A handshake on an entry with `vld==0` sets `err_o`, which stays set until reset. The response is still forwarded, with `rsp_id_o` taken from the stale `in_id`. The table is not modified.
- Simultaneous request increment and response decrement on the same entry: `cnt` is unchanged and `vld` stays 1. The entry is not freed, even if `cnt` was 1.
- An entry freed in cycle t is allocatable from t+1 only. Allocation uses registered `vld`.
- Non-last response beats do not change the table.
- Stability: while `req_valid_i` is held, `can_issue` cannot fall. Only request handshakes consume capacity, so `req_valid_o` obeys valid/ready stability.
- Reset mid-operation clears the table. Outstanding downstream transactions are lost; the system resets downstream together with this block.

## Timing
- Zero-cycle combinational request and response paths; table update on the handshake clock edge.
- No combinational path from `rsp_*` to `req_ready_o`.
- Reset values:
  - all `vld=0`, `cnt=0`, `in_id=0`
  - `err_o=0`, `busy_o=0`
  - `req_valid_o=0` (because `req_valid_i` is low during reset)
  - `rsp_valid_o` follows `rsp_valid_i`
- `busy_o` is registered OR of `vld`, valid the cycle after the causing handshake.
- Throughput: one request and one response beat per cycle.

## Test plan
- Reset, then 4 requests with IDs 0x05, 0x05, 0x12, 0x3F, `req_ready_i=1` -> `req_id_o` = 0,0,1,2; `cnt[0]=2`; `busy_o=1` next cycle.
- 4 requests with ID 0x09, then a 5th with ID 0x09 (`MaxTxnsPerId=4`) -> 5th stalls with `req_ready_o=0`, `req_valid_o=0`. One last-response on id 0 -> 5th issues the next cycle with `req_id_o=0`.
- Fill 4 entries with IDs 1,2,3,4, then ID 7 -> stall. Last-response freeing entry 2 in cycle t -> ID 7 issues at t+1 with `req_id_o=2`.
- Single outstanding on entry 0 (cnt=1), same cycle as a last-response on id 0 plus a new request with the same in_id -> `cnt` stays 1, `vld` stays 1, `req_id_o=0`.
- Multi-beat response (3 beats, last on 3rd) on id 1 with `in_id=0x2A` -> `rsp_id_o=0x2A` all beats; `cnt` decrements only on beat 3.
- Response on invalid id 3 -> forwarded, `err_o=1` and held; assert `rst_i` mid-burst -> table empty, `err_o=0`, `busy_o=0`.

Source files
------------

// File: rtl/cachepool_id_remapper.sv
// Transaction-ID remapper for one CachePool L2 channel: folds wide upstream IDs
// onto a small table of downstream IDs and restores them on the response path.
module cachepool_id_remapper #(
    parameter int InIdWidth    = 6,
    parameter int OutIdWidth   = 2,
    parameter int MaxTxnsPerId = 4,
    parameter int ReqWidth     = 64,
    parameter int RspWidth     = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    // Valid/ready on every channel: a beat transfers on a cycle where valid and
    // ready are both high; once valid is raised it is held until that transfer.
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [InIdWidth-1:0]  req_id_i,
    input  logic [ReqWidth-1:0]   req_data_i,
    output logic                  req_valid_o,
    input  logic                  req_ready_i,
    output logic [OutIdWidth-1:0] req_id_o,
    output logic [ReqWidth-1:0]   req_data_o,
    input  logic                  rsp_valid_i,
    output logic                  rsp_ready_o,
    input  logic [OutIdWidth-1:0] rsp_id_i,
    input  logic                  rsp_last_i,
    input  logic [RspWidth-1:0]   rsp_data_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [InIdWidth-1:0]  rsp_id_o,
    output logic                  rsp_last_o,
    output logic [RspWidth-1:0]   rsp_data_o,
    output logic                  busy_o,
    output logic                  err_o
);

    localparam int NumEntries = 2 ** OutIdWidth;
    localparam int CntWidth   = $clog2(MaxTxnsPerId + 1);

    typedef logic [CntWidth-1:0] cnt_t;

    logic [NumEntries-1:0] vld_q, vld_d;
    logic [InIdWidth-1:0]  in_id_q [NumEntries];
    logic [InIdWidth-1:0]  in_id_d [NumEntries];
    cnt_t                  cnt_q   [NumEntries];
    cnt_t                  cnt_d   [NumEntries];
    logic                  err_q;
    logic                  busy_q;

    logic                  hit;
    logic                  free_found;
    logic [OutIdWidth-1:0] hit_idx;
    logic [OutIdWidth-1:0] free_idx;
    logic [OutIdWidth-1:0] issue_idx;
    logic                  can_issue;
    logic                  req_hs;
    logic                  rsp_hs;
    logic                  rsp_dec;

    // Lookup uses only registered table state, so the response path never
    // reaches req_ready_o and a freed entry is allocatable one cycle later.
    always_comb begin
        hit        = 1'b0;
        hit_idx    = '0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int e = NumEntries - 1; e >= 0; e--) begin
            if (!vld_q[e]) begin
                free_found = 1'b1;
                free_idx   = OutIdWidth'(e);
            end
            if (vld_q[e] && (in_id_q[e] == req_id_i)) begin
                hit     = 1'b1;
                hit_idx = OutIdWidth'(e);
            end
        end
        issue_idx = hit ? hit_idx : free_idx;
        can_issue = hit ? (cnt_q[hit_idx] < cnt_t'(MaxTxnsPerId)) : free_found;
    end

    assign req_valid_o = req_valid_i & can_issue;
    assign req_ready_o = req_ready_i & can_issue;
    assign req_id_o    = issue_idx;
    assign req_data_o  = req_data_i;

    assign rsp_valid_o = rsp_valid_i;
    assign rsp_ready_o = rsp_ready_i;
    assign rsp_id_o    = in_id_q[rsp_id_i];
    assign rsp_last_o  = rsp_last_i;
    assign rsp_data_o  = rsp_data_i;

    assign req_hs  = req_valid_i & req_ready_i & can_issue;
    assign rsp_hs  = rsp_valid_i & rsp_ready_i;
    assign rsp_dec = rsp_hs & rsp_last_i & vld_q[rsp_id_i];

    // A same-cycle issue and retire on one entry cancel out and keep it alive.
    always_comb begin
        vld_d   = vld_q;
        in_id_d = in_id_q;
        cnt_d   = cnt_q;
        for (int e = 0; e < NumEntries; e++) begin
            if (req_hs && (issue_idx == OutIdWidth'(e)) &&
                !(rsp_dec && (rsp_id_i == OutIdWidth'(e)))) begin
                vld_d[e]   = 1'b1;
                in_id_d[e] = req_id_i;
                cnt_d[e]   = cnt_q[e] + cnt_t'(1);
            end else if (rsp_dec && (rsp_id_i == OutIdWidth'(e)) &&
                         !(req_hs && (issue_idx == OutIdWidth'(e)))) begin
                cnt_d[e] = cnt_q[e] - cnt_t'(1);
                if (cnt_q[e] == cnt_t'(1)) begin
                    vld_d[e] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_q  <= '0;
            err_q  <= 1'b0;
            busy_q <= 1'b0;
            for (int e = 0; e < NumEntries; e++) begin
                in_id_q[e] <= '0;
                cnt_q[e]   <= '0;
            end
        end else begin
            vld_q   <= vld_d;
            in_id_q <= in_id_d;
            cnt_q   <= cnt_d;
            busy_q  <= |vld_d;
            if (rsp_hs && !vld_q[rsp_id_i]) begin
                err_q <= 1'b1;
            end
        end
    end

    assign busy_o = busy_q;
    assign err_o  = err_q;

endmodule

// File: tb/tb_cachepool_id_remapper.sv
// Self-checking bench for cachepool_id_remapper: directed scenarios plus a
// randomized run against a table-level reference model.
module tb_cachepool_id_remapper;

    localparam int InW = 6, OutW = 2, MaxT = 4, ReqW = 64, RspW = 64;
    localparam int NE = 4;

    logic            clk_i = 1'b0;
    logic            rst_i = 1'b1;
    logic            req_valid_i = 1'b0, req_ready_o, req_valid_o, req_ready_i = 1'b0;
    logic [InW-1:0]  req_id_i = '0;
    logic [ReqW-1:0] req_data_i = '0, req_data_o;
    logic [OutW-1:0] req_id_o;
    logic            rsp_valid_i = 1'b0, rsp_ready_o, rsp_valid_o, rsp_ready_i = 1'b0;
    logic [OutW-1:0] rsp_id_i = '0;
    logic            rsp_last_i = 1'b0, rsp_last_o;
    logic [RspW-1:0] rsp_data_i = '0, rsp_data_o;
    logic [InW-1:0]  rsp_id_o;
    logic            busy_o, err_o;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    // Reference model: per-slot owner ID, outstanding count, sticky error.
    bit m_vld [NE];
    int m_id  [NE];
    int m_cnt [NE];
    bit m_err;

    cachepool_id_remapper #(
        .InIdWidth(InW), .OutIdWidth(OutW), .MaxTxnsPerId(MaxT),
        .ReqWidth(ReqW), .RspWidth(RspW)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_id_i(req_id_i), .req_data_i(req_data_i),
        .req_valid_o(req_valid_o), .req_ready_i(req_ready_i),
        .req_id_o(req_id_o), .req_data_o(req_data_o),
        .rsp_valid_i(rsp_valid_i), .rsp_ready_o(rsp_ready_o),
        .rsp_id_i(rsp_id_i), .rsp_last_i(rsp_last_i), .rsp_data_i(rsp_data_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_id_o(rsp_id_o), .rsp_last_o(rsp_last_o), .rsp_data_o(rsp_data_o),
        .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic void model_clear();
        for (int e = 0; e < NE; e++) begin
            m_vld[e] = 0; m_id[e] = 0; m_cnt[e] = 0;
        end
        m_err = 0;
    endfunction

    // Hit on a live slot with the same owner, otherwise the lowest idle slot.
    function automatic void predict(input int rid, output bit can, output int idx);
        can = 0; idx = 0;
        for (int e = 0; e < NE; e++)
            if (m_vld[e] && m_id[e] == rid) begin
                idx = e; can = (m_cnt[e] < MaxT); return;
            end
        for (int e = 0; e < NE; e++)
            if (!m_vld[e]) begin
                idx = e; can = 1; return;
            end
    endfunction

    function automatic bit model_busy();
        bit b = 0;
        for (int e = 0; e < NE; e++) b |= m_vld[e];
        return b;
    endfunction

    function automatic void model_step();
        bit can; int idx; bit req_hs, rsp_hs, dec; int sid;
        predict(int'(req_id_i), can, idx);
        req_hs = req_valid_i && req_ready_i && can;
        rsp_hs = rsp_valid_i && rsp_ready_i;
        sid    = int'(rsp_id_i);
        dec    = rsp_hs && rsp_last_i && m_vld[sid];
        if (rsp_hs && !m_vld[sid]) m_err = 1;
        if (req_hs && dec && idx == sid) return;
        if (req_hs) begin
            m_vld[idx] = 1; m_id[idx] = int'(req_id_i); m_cnt[idx]++;
        end
        if (dec) begin
            m_cnt[sid]--;
            if (m_cnt[sid] == 0) m_vld[sid] = 0;
        end
    endfunction

    task automatic idle_inputs();
        req_valid_i = 0; req_ready_i = 1; req_id_i = '0;
        rsp_valid_i = 0; rsp_ready_i = 1; rsp_id_i = '0; rsp_last_i = 0;
    endtask

    task automatic tick();
        @(posedge clk_i);
        model_step();
        #1;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst_i = 1;
        model_clear();
        repeat (2) @(posedge clk_i);
        #1 rst_i = 0;
    endtask

    task automatic set_req(input int id);
        req_valid_i = 1; req_id_i = InW'(id); req_ready_i = 1;
    endtask

    task automatic set_rsp(input int id, input bit last);
        rsp_valid_i = 1; rsp_id_i = OutW'(id); rsp_last_i = last; rsp_ready_i = 1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_i = 1; rsp_valid_i = 1;
        model_clear();
        @(negedge clk_i);
        chk_cnt++; if (busy_o !== 1'b0) $display("FAIL reset_busy act=%b exp=0", busy_o); else pass_cnt++;
        chk_cnt++; if (err_o !== 1'b0) $display("FAIL reset_err act=%b exp=0", err_o); else pass_cnt++;
        chk_cnt++; if (req_valid_o !== 1'b0) $display("FAIL reset_req_valid act=%b exp=0", req_valid_o); else pass_cnt++;
        chk_cnt++; if (rsp_valid_o !== 1'b1) $display("FAIL reset_rsp_valid act=%b exp=1", rsp_valid_o); else pass_cnt++;
        chk_cnt++; if (rsp_id_o !== 6'h00) $display("FAIL reset_rsp_id act=%h exp=00", rsp_id_o); else pass_cnt++;
        rsp_valid_i = 0;
        #1 rst_i = 0;
    endtask

    task automatic test_basic_remap();
        int ids[4] = '{'h05, 'h05, 'h12, 'h3F};
        int exp[4] = '{0, 0, 1, 2};
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            set_req(ids[i]);
            @(negedge clk_i);
            chk_cnt++; if (req_valid_o !== 1'b1) $display("FAIL basic_valid[%0d] act=%b exp=1", i, req_valid_o); else pass_cnt++;
            chk_cnt++; if (req_id_o !== OutW'(exp[i])) $display("FAIL basic_id[%0d] act=%0d exp=%0d", i, req_id_o, exp[i]); else pass_cnt++;
            tick();
        end
        idle_inputs();
        @(negedge clk_i);
        chk_cnt++; if (busy_o !== 1'b1) $display("FAIL basic_busy act=%b exp=1", busy_o); else pass_cnt++;
        // Entry 0 holds two transactions: one retire keeps it live for 0x05.
        set_rsp(0, 1);
        tick();
        idle_inputs(); set_req('h05);
        @(negedge clk_i);
        chk_cnt++; if (req_id_o !== 2'd0 || req_valid_o !== 1'b1) $display("FAIL basic_cnt2 act=%0d/%b exp=0/1", req_id_o, req_valid_o); else pass_cnt++;
        idle_inputs();
    endtask

    task automatic test_per_id_limit();
        apply_reset();
        for (int i = 0; i < MaxT; i++) begin
            set_req('h09);
            tick();
        end
        set_req('h09);
        set_rsp(0, 1);
        @(negedge clk_i);
        chk_cnt++; if (req_ready_o !== 1'b0) $display("FAIL limit_ready act=%b exp=0", req_ready_o); else pass_cnt++;
        chk_cnt++; if (req_valid_o !== 1'b0) $display("FAIL limit_valid act=%b exp=0", req_valid_o); else pass_cnt++;
        tick();
        rsp_valid_i = 0;
        @(negedge clk_i);
        chk_cnt++; if (req_valid_o !== 1'b1 || req_id_o !== 2'd0) $display("FAIL limit_release act=%b/%0d exp=1/0", req_valid_o, req_id_o); else pass_cnt++;
        tick();
        idle_inputs();
    endtask

    task automatic test_table_full();
        apply_reset();
        for (int i = 1; i <= 4; i++) begin
            set_req(i);
            tick();
        end
        set_req(7);
        set_rsp(2, 1);
        @(negedge clk_i);
        chk_cnt++; if (req_ready_o !== 1'b0) $display("FAIL full_stall act=%b exp=0", req_ready_o); else pass_cnt++;
        tick();
        rsp_valid_i = 0;
        @(negedge clk_i);
        chk_cnt++; if (req_valid_o !== 1'b1 || req_id_o !== 2'd2) $display("FAIL full_reuse act=%b/%0d exp=1/2", req_valid_o, req_id_o); else pass_cnt++;
        tick();
        idle_inputs();
    endtask

    task automatic test_simultaneous();
        apply_reset();
        set_req('h11);
        tick();
        set_req('h11);
        set_rsp(0, 1);
        @(negedge clk_i);
        chk_cnt++; if (req_valid_o !== 1'b1 || req_id_o !== 2'd0) $display("FAIL simul_issue act=%b/%0d exp=1/0", req_valid_o, req_id_o); else pass_cnt++;
        tick();
        idle_inputs();
        @(negedge clk_i);
        chk_cnt++; if (busy_o !== 1'b1) $display("FAIL simul_keep act=%b exp=1", busy_o); else pass_cnt++;
        set_rsp(0, 1);
        tick();
        idle_inputs();
        @(negedge clk_i);
        chk_cnt++; if (busy_o !== 1'b0) $display("FAIL simul_free act=%b exp=0", busy_o); else pass_cnt++;
    endtask

    task automatic test_multibeat();
        apply_reset();
        set_req('h01); tick();
        set_req('h2A); tick();
        idle_inputs();
        for (int b = 0; b < 3; b++) begin
            set_rsp(1, b == 2);
            rsp_data_i = {$urandom, $urandom};
            @(negedge clk_i);
            chk_cnt++; if (rsp_id_o !== 6'h2A) $display("FAIL beat_id[%0d] act=%h exp=2a", b, rsp_id_o); else pass_cnt++;
            chk_cnt++; if (rsp_last_o !== (b == 2) || rsp_data_o !== rsp_data_i) $display("FAIL beat_pass[%0d] act=%b exp=%b", b, rsp_last_o, b == 2); else pass_cnt++;
            tick();
            if (b < 2) begin
                rsp_valid_i = 0; set_req('h2A);
                @(negedge clk_i);
                chk_cnt++; if (req_id_o !== 2'd1) $display("FAIL beat_keep[%0d] act=%0d exp=1", b, req_id_o); else pass_cnt++;
                req_valid_i = 0;
            end
        end
        idle_inputs(); set_req('h33);
        @(negedge clk_i);
        chk_cnt++; if (req_id_o !== 2'd1) $display("FAIL beat_freed act=%0d exp=1", req_id_o); else pass_cnt++;
        idle_inputs();
    endtask

    task automatic test_err_and_reset();
        apply_reset();
        set_rsp(3, 1);
        @(negedge clk_i);
        chk_cnt++; if (rsp_valid_o !== 1'b1 || rsp_id_o !== 6'h00) $display("FAIL err_fwd act=%b/%h exp=1/00", rsp_valid_o, rsp_id_o); else pass_cnt++;
        tick();
        idle_inputs();
        repeat (2) tick();
        @(negedge clk_i);
        chk_cnt++; if (err_o !== 1'b1) $display("FAIL err_sticky act=%b exp=1", err_o); else pass_cnt++;
        chk_cnt++; if (busy_o !== 1'b0) $display("FAIL err_notable act=%b exp=0", busy_o); else pass_cnt++;
        set_req('h15); tick();
        set_req('h16); tick();
        set_rsp(0, 0);
        @(posedge clk_i);
        #2 rst_i = 1;
        model_clear();
        #1;
        chk_cnt++; if (busy_o !== 1'b0 || err_o !== 1'b0) $display("FAIL midrst act=%b/%b exp=0/0", busy_o, err_o); else pass_cnt++;
        idle_inputs();
        @(negedge clk_i);
        rst_i = 0;
        set_req('h16);
        @(negedge clk_i);
        chk_cnt++; if (req_id_o !== 2'd0) $display("FAIL midrst_empty act=%0d exp=0", req_id_o); else pass_cnt++;
        idle_inputs();
    endtask

    task automatic test_random();
        bit can; int idx;
        int errs = 0;
        apply_reset();
        for (int c = 0; c < 600; c++) begin
            req_valid_i = ($urandom_range(0, 9) < 7);
            req_id_i    = InW'($urandom_range(0, 6));
            req_ready_i = ($urandom_range(0, 9) < 8);
            req_data_i  = {$urandom, $urandom};
            rsp_id_i    = OutW'($urandom_range(0, NE - 1));
            rsp_valid_i = ($urandom_range(0, 9) < 6) && (m_vld[rsp_id_i] || $urandom_range(0, 49) == 0);
            rsp_ready_i = ($urandom_range(0, 9) < 8);
            rsp_last_i  = ($urandom_range(0, 2) != 0);
            rsp_data_i  = {$urandom, $urandom};
            predict(int'(req_id_i), can, idx);
            @(negedge clk_i);
            if (req_valid_o !== (req_valid_i & can) || req_ready_o !== (req_ready_i & can) ||
                (can && req_id_o !== OutW'(idx)) || req_data_o !== req_data_i ||
                rsp_valid_o !== rsp_valid_i || rsp_ready_o !== rsp_ready_i ||
                rsp_id_o !== InW'(m_id[rsp_id_i]) || rsp_data_o !== rsp_data_i ||
                busy_o !== model_busy() || err_o !== m_err) begin
                errs++;
                if (errs <= 5)
                    $display("FAIL rand_cycle[%0d] act v=%b r=%b id=%0d rid=%h busy=%b err=%b exp v=%b r=%b id=%0d rid=%h busy=%b err=%b",
                             c, req_valid_o, req_ready_o, req_id_o, rsp_id_o, busy_o, err_o,
                             req_valid_i & can, req_ready_i & can, idx, m_id[rsp_id_i], model_busy(), m_err);
            end
            chk_cnt++; if (errs == 0) pass_cnt++;
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_basic_remap();
        test_per_id_limit();
        test_table_full();
        test_simultaneous();
        test_multibeat();
        test_err_and_reset();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout act=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
